priority_service_seq: RTL and testbench

- Downstream consumer of the 3-input priority encoder. It takes the encoder's 2-bit code (11 = input a, highest priority; 10 = b; 01 = c; 00 = none).
- It qualifies the code against glitches, then serves one request at a time for a fixed number of cycles, non-preemptively. During service it drives a one-hot grant.
- After each service it enforces a hold-off gap and counts completed services per channel.

---
 rtl/priority_service_seq.sv | 149 ++++++++++++++
 tb/tb_priority_service_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_service_seq.sv
`timescale 1ns/1ps
// priority_service_seq
// Qualifies the 2-bit priority-encoder code ({11=a, 10=b, 01=c, 00=none}),
// then serves one channel at a time for SERVICE_CYCLES cycles without
// preemption. A HOLDOFF_CYCLES gap follows every service. Completed services
// are counted per channel in saturating counters.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   code_in      encoded request (may be glitchy/asynchronous)
//   clr_cnt      synchronous clear of all counters (wins over increment)
//   grant        one-hot grant {a,b,c}, 000 when not serving
//   busy         high in SERVE and HOLDOFF
//   done         one-cycle pulse after the last grant cycle
//   served_code  code currently or most recently served
//   cnt_a/b/c    completed services per channel
module priority_service_seq #(
   parameter int unsigned SERVICE_CYCLES = 4,
   parameter int unsigned HOLDOFF_CYCLES = 2,
   parameter int unsigned CNT_W          = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       code_in,
   input  logic             clr_cnt,
   output logic [2:0]       grant,
   output logic             busy,
   output logic             done,
   output logic [1:0]       served_code,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b,
   output logic [CNT_W-1:0] cnt_c
);

   localparam int unsigned MAX_CYC = (SERVICE_CYCLES > HOLDOFF_CYCLES) ?
                                     SERVICE_CYCLES : HOLDOFF_CYCLES;
   localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [TMR_W-1:0] SVC_LAST  = TMR_W'(SERVICE_CYCLES - 1);
   localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLDOFF_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE   = 2'd1,
      HOLDOFF = 2'd2
   } state_t;

   state_t           state;
   logic [1:0]       code_q1;
   logic [1:0]       code_q2;
   logic [TMR_W-1:0] timer;
   logic             req_ok;
   logic             svc_end;

   // Code-to-grant mapping: a is the highest-priority channel.
   function automatic logic [2:0] decode_grant(input logic [1:0] c);
      case (c)
         2'b11:   decode_grant = 3'b100;
         2'b10:   decode_grant = 3'b010;
         2'b01:   decode_grant = 3'b001;
         default: decode_grant = 3'b000;
      endcase
   endfunction

   // Two samples must agree, so a one-sample glitch never qualifies.
   assign req_ok  = (code_q1 == code_q2) && (code_q2 != 2'b00);
   assign svc_end = (state == SERVE) && (timer == SVC_LAST);

   // Input synchronizer / glitch filter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_q1 <= 2'b00;
         code_q2 <= 2'b00;
      end else begin
         code_q1 <= code_in;
         code_q2 <= code_q1;
      end
   end

   // Service FSM with registered grant/busy/done/served_code.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         timer       <= '0;
         grant       <= 3'b000;
         busy        <= 1'b0;
         done        <= 1'b0;
         served_code <= 2'b00;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req_ok) begin
                  state       <= SERVE;
                  served_code <= code_q2;
                  timer       <= '0;
                  grant       <= decode_grant(code_q2);
                  busy        <= 1'b1;
               end
            end
            SERVE: begin
               if (timer == SVC_LAST) begin
                  state <= HOLDOFF;
                  timer <= '0;
                  grant <= 3'b000;
                  done  <= 1'b1;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            HOLDOFF: begin
               if (timer == HOLD_LAST) begin
                  state <= IDLE;
                  timer <= '0;
                  busy  <= 1'b0;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               timer <= '0;
               grant <= 3'b000;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Saturating per-channel service counters; clear has priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_a <= '0;
         cnt_b <= '0;
         cnt_c <= '0;
      end else if (clr_cnt) begin
         cnt_a <= '0;
         cnt_b <= '0;
         cnt_c <= '0;
      end else if (svc_end) begin
         case (served_code)
            2'b11:   if (cnt_a != '1) cnt_a <= cnt_a + CNT_W'(1);
            2'b10:   if (cnt_b != '1) cnt_b <= cnt_b + CNT_W'(1);
            2'b01:   if (cnt_c != '1) cnt_c <= cnt_c + CNT_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_priority_service_seq.sv
`timescale 1ns/1ps
// Bench for priority_service_seq. Expected service completions are queued when
// a request is driven; a monitor pops them on every done pulse and checks the
// served code and the resulting counter value. Scenario tasks check grant,
// busy and done timing inline.
module tb_priority_service_seq;

   localparam int unsigned CNT_W = 2;

   typedef struct {
      logic [1:0]       code;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [1:0]       code_in = 2'b00;
   logic             clr_cnt = 1'b0;
   logic [2:0]       grant;
   logic             busy;
   logic             done;
   logic [1:0]       served_code;
   logic [CNT_W-1:0] cnt_a;
   logic [CNT_W-1:0] cnt_b;
   logic [CNT_W-1:0] cnt_c;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   priority_service_seq #(
      .SERVICE_CYCLES(4),
      .HOLDOFF_CYCLES(2),
      .CNT_W         (CNT_W)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .code_in    (code_in),
      .clr_cnt    (clr_cnt),
      .grant      (grant),
      .busy       (busy),
      .done       (done),
      .served_code(served_code),
      .cnt_a      (cnt_a),
      .cnt_b      (cnt_b),
      .cnt_c      (cnt_c)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   function automatic logic [CNT_W-1:0] cnt_of(input logic [1:0] c);
      case (c)
         2'b11:   cnt_of = cnt_a;
         2'b10:   cnt_of = cnt_b;
         default: cnt_of = cnt_c;
      endcase
   endfunction

   // Scoreboard monitor: every done pulse must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL done_unexpected: done=1 with nothing pending, served_code=%b", served_code);
         end else begin
            e = sb_q.pop_front();
            if (served_code !== e.code) begin
               n_fail++;
               $display("FAIL done_code: got %b, expected %b", served_code, e.code);
            end
            n_checks++;
            if (cnt_of(e.code) !== e.cnt) begin
               n_fail++;
               $display("FAIL done_cnt: code %b count got %0d, expected %0d",
                        e.code, cnt_of(e.code), e.cnt);
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push_exp(input logic [1:0] c, input int n);
      exp_t e;
      e.code = c;
      e.cnt  = CNT_W'(n);
      sb_q.push_back(e);
   endtask

   task automatic apply_reset();
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_pending: %0d services never completed, expected 0", sb_q.size());
      end
      sb_q.delete();
      rst_n   = 1'b0;
      code_in = 2'b00;
      clr_cnt = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_grant(input string name, input int bound);
      int i;
      for (i = 0; i < bound; i++) begin
         tick();
         if (grant != 3'b000) break;
      end
      n_checks++;
      if (i == bound) begin
         n_fail++;
         $display("FAIL %s: no grant within %0d cycles, got grant=%b", name, bound, grant);
      end
   endtask

   task automatic wait_done(input string name, input int bound);
      int i;
      for (i = 0; i < bound; i++) begin
         tick();
         if (done) break;
      end
      n_checks++;
      if (i == bound) begin
         n_fail++;
         $display("FAIL %s: no done within %0d cycles, got done=%b", name, bound, done);
      end
   endtask

   task automatic wait_idle(input string name, input int bound);
      int i;
      for (i = 0; i < bound; i++) begin
         tick();
         if (!busy && grant == 3'b000 && !done) break;
      end
      n_checks++;
      if (i == bound) begin
         n_fail++;
         $display("FAIL %s: not idle within %0d cycles, got busy=%b grant=%b", name, bound, busy, grant);
      end
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      code_in = 2'b11;
      repeat (3) tick();
      n_checks++;
      if ({grant, busy, done, served_code} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: grant=%b busy=%b done=%b served=%b, expected all 0",
                  grant, busy, done, served_code);
      end
      n_checks++;
      if ({cnt_a, cnt_b, cnt_c} !== '0) begin
         n_fail++;
         $display("FAIL reset_counters: a=%0d b=%0d c=%0d, expected 0", cnt_a, cnt_b, cnt_c);
      end
      code_in = 2'b00;
      rst_n   = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         n_checks++;
         if ({grant, busy, done, served_code, cnt_a, cnt_b, cnt_c} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: cycle %0d grant=%b busy=%b done=%b, expected quiet", k, grant, busy, done);
         end
      end
   endtask

   task automatic test_single_service();
      logic [2:0] eg;
      logic       eb;
      logic       ed;
      apply_reset();
      code_in = 2'b11;
      push_exp(2'b11, 1);
      push_exp(2'b11, 2);
      // k = index of the rising edge just passed, edge 0 being the first sample.
      for (int k = 0; k <= 12; k++) begin
         tick();
         eg = ((k >= 2 && k <= 5) || (k >= 9)) ? 3'b100 : 3'b000;
         eb = (k >= 2 && k <= 7) || (k >= 9);
         ed = (k == 6);
         n_checks++;
         if (grant !== eg || busy !== eb || done !== ed) begin
            n_fail++;
            $display("FAIL single_timing: edge %0d got grant=%b busy=%b done=%b, expected %b %b %b",
                     k, grant, busy, done, eg, eb, ed);
         end
      end
      code_in = 2'b00;
      wait_idle("single_idle", 20);
   endtask

   task automatic test_glitch();
      apply_reset();
      code_in = 2'b10;
      tick();
      code_in = 2'b00;
      for (int k = 0; k < 6; k++) begin
         tick();
         n_checks++;
         if (grant !== 3'b000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_grant: cycle %0d grant=%b busy=%b, expected 000 0", k, grant, busy);
         end
      end
      n_checks++;
      if (cnt_b !== '0) begin
         n_fail++;
         $display("FAIL glitch_cnt: cnt_b=%0d, expected 0", cnt_b);
      end
   endtask

   task automatic test_non_preemption();
      apply_reset();
      code_in = 2'b01;
      push_exp(2'b01, 1);
      push_exp(2'b11, 1);
      wait_grant("nonpre_first", 10);
      n_checks++;
      if (grant !== 3'b001) begin
         n_fail++;
         $display("FAIL nonpre_first_grant: got %b, expected 001", grant);
      end
      code_in = 2'b11;
      for (int k = 1; k < 4; k++) begin
         tick();
         n_checks++;
         if (grant !== 3'b001 || served_code !== 2'b01) begin
            n_fail++;
            $display("FAIL nonpre_hold: serve cycle %0d grant=%b served=%b, expected 001 01",
                     k, grant, served_code);
         end
      end
      tick();
      n_checks++;
      if (grant !== 3'b000 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL nonpre_end: grant=%b done=%b, expected 000 1", grant, done);
      end
      wait_grant("nonpre_second", 10);
      n_checks++;
      if (grant !== 3'b100 || served_code !== 2'b11) begin
         n_fail++;
         $display("FAIL nonpre_second_grant: grant=%b served=%b, expected 100 11", grant, served_code);
      end
      code_in = 2'b00;
      wait_idle("nonpre_idle", 20);
   endtask

   task automatic test_saturation_clear();
      apply_reset();
      code_in = 2'b10;
      push_exp(2'b10, 1);
      push_exp(2'b10, 2);
      push_exp(2'b10, 3);
      push_exp(2'b10, 3);
      push_exp(2'b10, 3);
      push_exp(2'b10, 3);
      for (int s = 0; s < 6; s++) wait_done("sat_done", 12);
      // Clear on the done cycle of the sixth service.
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      n_checks++;
      if (cnt_b !== '0) begin
         n_fail++;
         $display("FAIL clr_on_done: cnt_b=%0d, expected 0", cnt_b);
      end
      // Clear coinciding with the increment edge of the seventh service.
      push_exp(2'b10, 0);
      wait_grant("clr_coincide_grant", 10);
      repeat (3) tick();
      n_checks++;
      if (grant !== 3'b010) begin
         n_fail++;
         $display("FAIL clr_coincide_last: grant=%b, expected 010", grant);
      end
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      n_checks++;
      if (done !== 1'b1 || cnt_b !== '0) begin
         n_fail++;
         $display("FAIL clr_coincide: done=%b cnt_b=%0d, expected 1 0", done, cnt_b);
      end
      code_in = 2'b00;
      wait_idle("sat_idle", 20);
   endtask

   task automatic test_reset_mid_service();
      apply_reset();
      code_in = 2'b11;
      wait_grant("midrst_grant", 10);
      tick();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (grant !== 3'b000 || busy !== 1'b0 || cnt_a !== '0) begin
         n_fail++;
         $display("FAIL midrst_drop: grant=%b busy=%b cnt_a=%0d, expected 000 0 0", grant, busy, cnt_a);
      end
      code_in = 2'b00;
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         n_checks++;
         if (done !== 1'b0 || grant !== 3'b000 || cnt_a !== '0) begin
            n_fail++;
            $display("FAIL midrst_after: cycle %0d done=%b grant=%b cnt_a=%0d, expected 0 000 0",
                     k, done, grant, cnt_a);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_service();
      test_glitch();
      test_non_preemption();
      test_saturation_clear();
      test_reset_mid_service();
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_final: %0d services never completed, expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
